// File: rtl/misaligned_load_unit_if.sv
// Request, memory-beat and writeback channels of misaligned_load_unit.
// The unit itself uses the slave modport; its environment uses master.
interface misaligned_load_unit_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_func3;
    logic [4:0]            req_rd;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [XLEN-1:0]       mem_rsp_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [XLEN-1:0]       rsp_data;
    logic [4:0]            rsp_rd;
    logic                  rsp_misaligned;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_addr, req_func3, req_rd,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
        output req_ready, mem_req_valid, mem_req_addr,
        output rsp_valid, rsp_data, rsp_rd, rsp_misaligned, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_func3, req_rd,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
        input  req_ready, mem_req_valid, mem_req_addr,
        input  rsp_valid, rsp_data, rsp_rd, rsp_misaligned, rsp_err
    );
endinterface

// File: rtl/misaligned_load_unit.sv
// Load unit that splits XLEN-boundary-crossing loads into two aligned beats,
// stitches them, and returns the size-selected, extended result.
module misaligned_load_unit #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    misaligned_load_unit_if.slave io_bus
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    typedef enum logic [2:0] {StIdle, StReq0, StWait0, StReq1, StWait1, StResp} state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_mem_req_valid;
    logic [ADDR_WIDTH-1:0] r_mem_req_addr;
    logic [2:0]            r_func3;
    logic [OFFW-1:0]       r_off;
    logic [4:0]            r_rd;
    logic [XLEN-1:0]       r_beat0;
    logic                  r_rsp_valid;
    logic [XLEN-1:0]       r_rsp_data;
    logic                  r_rsp_misaligned;
    logic                  r_rsp_err;

    logic [XLEN-1:0]       w_beat0;
    logic [XLEN-1:0]       w_beat1;
    logic [XLEN-1:0]       w_shifted;
    logic [XLEN-1:0]       w_mask;
    logic [XLEN-1:0]       w_result;
    logic [3:0]            w_size;
    logic [OFFW+1:0]       w_end;
    logic                  w_cross;
    logic                  w_sign;
    logic                  w_illegal;

    // Result is formed from the live response beat so it can be registered on capture.
    always_comb begin
        w_beat0   = (r_state == StWait0) ? io_bus.mem_rsp_data : r_beat0;
        w_beat1   = (r_state == StWait1) ? io_bus.mem_rsp_data : '0;
        w_shifted = XLEN'({w_beat1, w_beat0} >> {r_off, 3'b000});
        w_size    = 4'd1 << r_func3[1:0];
        w_end     = (OFFW+2)'(r_off) + (OFFW+2)'(w_size);
        w_cross   = w_end > (OFFW+2)'(BYTES);
        w_mask    = '1;
        w_sign    = w_shifted[XLEN-1];
        unique case (r_func3[1:0])
            2'b00: begin
                w_mask = XLEN'(8'hFF);
                w_sign = w_shifted[7];
            end
            2'b01: begin
                w_mask = XLEN'(16'hFFFF);
                w_sign = w_shifted[15];
            end
            2'b10: begin
                w_mask = XLEN'(32'hFFFF_FFFF);
                w_sign = w_shifted[31];
            end
            default: ;
        endcase
        w_result  = (w_shifted & w_mask) | ((w_sign && !r_func3[2]) ? ~w_mask : '0);
        w_illegal = (io_bus.req_func3 == 3'b111) ||
                    ((XLEN == 32) && (io_bus.req_func3 == 3'b011 || io_bus.req_func3 == 3'b110));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= StIdle;
            r_req_ready      <= 1'b0;
            r_mem_req_valid  <= 1'b0;
            r_mem_req_addr   <= '0;
            r_func3          <= '0;
            r_off            <= '0;
            r_rd             <= '0;
            r_beat0          <= '0;
            r_rsp_valid      <= 1'b0;
            r_rsp_data       <= '0;
            r_rsp_misaligned <= 1'b0;
            r_rsp_err        <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_req_ready <= 1'b1;
                    if (io_bus.req_valid && r_req_ready) begin
                        r_req_ready      <= 1'b0;
                        r_func3          <= io_bus.req_func3;
                        r_off            <= io_bus.req_addr[OFFW-1:0];
                        r_rd             <= io_bus.req_rd;
                        r_rsp_misaligned <= 1'b0;
                        if (w_illegal) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                            r_state     <= StResp;
                        end else begin
                            r_rsp_err       <= 1'b0;
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_addr  <= {io_bus.req_addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
                            r_state         <= StReq0;
                        end
                    end
                end
                StReq0, StReq1: begin
                    if (io_bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= (r_state == StReq0) ? StWait0 : StWait1;
                    end
                end
                StWait0: begin
                    if (io_bus.mem_rsp_valid) begin
                        r_beat0 <= io_bus.mem_rsp_data;
                        if (w_cross) begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_addr  <= r_mem_req_addr + ADDR_WIDTH'(BYTES);
                            r_state         <= StReq1;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_result;
                            r_state     <= StResp;
                        end
                    end
                end
                StWait1: begin
                    if (io_bus.mem_rsp_valid) begin
                        r_rsp_valid      <= 1'b1;
                        r_rsp_data       <= w_result;
                        r_rsp_misaligned <= 1'b1;
                        r_state          <= StResp;
                    end
                end
                StResp: begin
                    if (io_bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.req_ready      = r_req_ready;
    assign io_bus.mem_req_valid  = r_mem_req_valid;
    assign io_bus.mem_req_addr   = r_mem_req_addr;
    assign io_bus.rsp_valid      = r_rsp_valid;
    assign io_bus.rsp_data       = r_rsp_data;
    assign io_bus.rsp_rd         = r_rd;
    assign io_bus.rsp_misaligned = r_rsp_misaligned;
    assign io_bus.rsp_err        = r_rsp_err;
endmodule

// File: tb/tb_misaligned_load_unit.sv
// Randomized bench for misaligned_load_unit at XLEN=32 and XLEN=64, checked
// against a byte-addressed memory model.
module tb_misaligned_load_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel64         = 1'b0;
    logic        req_valid     = 1'b0;
    logic [31:0] req_addr      = '0;
    logic [2:0]  req_func3     = '0;
    logic [4:0]  req_rd        = '0;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data  = '0;
    logic        rsp_ready     = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    misaligned_load_unit_if #(.XLEN(32), .ADDR_WIDTH(32)) bus32 ();
    misaligned_load_unit_if #(.XLEN(64), .ADDR_WIDTH(32)) bus64 ();

    misaligned_load_unit #(.XLEN(32), .ADDR_WIDTH(32)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus32)
    );
    misaligned_load_unit #(.XLEN(64), .ADDR_WIDTH(32)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus64)
    );

    assign bus32.req_valid     = req_valid & ~sel64;
    assign bus32.req_addr      = req_addr;
    assign bus32.req_func3     = req_func3;
    assign bus32.req_rd        = req_rd;
    assign bus32.mem_req_ready = mem_req_ready;
    assign bus32.mem_rsp_valid = mem_rsp_valid & ~sel64;
    assign bus32.mem_rsp_data  = mem_rsp_data[31:0];
    assign bus32.rsp_ready     = rsp_ready;
    assign bus64.req_valid     = req_valid & sel64;
    assign bus64.req_addr      = req_addr;
    assign bus64.req_func3     = req_func3;
    assign bus64.req_rd        = req_rd;
    assign bus64.mem_req_ready = mem_req_ready;
    assign bus64.mem_rsp_valid = mem_rsp_valid & sel64;
    assign bus64.mem_rsp_data  = mem_rsp_data;
    assign bus64.rsp_ready     = rsp_ready;

    logic        o_req_ready, o_mem_req_valid, o_rsp_valid, o_rsp_mis, o_rsp_err;
    logic [31:0] o_mem_req_addr;
    logic [63:0] o_rsp_data;
    logic [4:0]  o_rsp_rd;
    assign o_req_ready     = sel64 ? bus64.req_ready      : bus32.req_ready;
    assign o_mem_req_valid = sel64 ? bus64.mem_req_valid  : bus32.mem_req_valid;
    assign o_mem_req_addr  = sel64 ? bus64.mem_req_addr   : bus32.mem_req_addr;
    assign o_rsp_valid     = sel64 ? bus64.rsp_valid      : bus32.rsp_valid;
    assign o_rsp_data      = sel64 ? bus64.rsp_data       : {32'h0, bus32.rsp_data};
    assign o_rsp_rd        = sel64 ? bus64.rsp_rd         : bus32.rsp_rd;
    assign o_rsp_mis       = sel64 ? bus64.rsp_misaligned : bus32.rsp_misaligned;
    assign o_rsp_err       = sel64 ? bus64.rsp_err        : bus32.rsp_err;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Byte-addressed memory; unwritten bytes follow a fixed address hash.
    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [63:0] read_bytes(input logic [31:0] a, input int n);
        logic [63:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[8*i +: 8] = mem_byte(a + 32'(i));
        return d;
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    function automatic logic ref_illegal(input logic [2:0] f3, input int xlen);
        return (f3 == 3'b111) || (xlen == 32 && (f3 == 3'b011 || f3 == 3'b110));
    endfunction

    function automatic logic [63:0] ref_load(input logic [31:0] a, input logic [2:0] f3,
                                             input int xlen);
        int          size;
        logic [63:0] v;
        size = 1 << f3[1:0];
        v    = read_bytes(a, size);
        if (!f3[2] && size * 8 < xlen && v[size*8-1]) v = v | ({64{1'b1}} << (size * 8));
        if (xlen == 32) v[63:32] = '0;
        return v;
    endfunction

    // Runs one load end to end, acting as memory and writeback, with per-beat request stalls.
    task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                            input int req_stall, input int rsp_stall);
        int          xlen, nb, size, exp_beats, exp_lat, nbeats, stall_left, rsp_left, cyc;
        logic        illegal, mis, seen, pending, done, got_rsp;
        logic [63:0] exp_data, pend_data, snap_data;
        logic [6:0]  snap_flags;
        logic [31:0] base, hold_addr;
        logic [31:0] beat_addr [2];
        xlen      = sel64 ? 64 : 32;
        nb        = xlen / 8;
        size      = 1 << f3[1:0];
        illegal   = ref_illegal(f3, xlen);
        mis       = !illegal && ((int'(a[2:0]) % nb) + size > nb);
        exp_data  = illegal ? 64'h0 : ref_load(a, f3, xlen);
        exp_beats = illegal ? 0 : (mis ? 2 : 1);
        exp_lat   = illegal ? 1 : (mis ? 5 + 2 * req_stall : 3 + req_stall);
        base      = a & ~32'(nb - 1);
        nbeats = 0; stall_left = req_stall; rsp_left = rsp_stall;
        seen = 0; pending = 0; done = 0; got_rsp = 0;
        pend_data = '0; snap_data = '0; snap_flags = '0; hold_addr = '0;
        beat_addr[0] = '0; beat_addr[1] = '0;

        check_val("req_ready_idle", {63'h0, o_req_ready}, 64'h1);
        req_valid = 1'b1; req_addr = a; req_func3 = f3; req_rd = rd;
        @(posedge clk); #1;
        cyc = 1;
        while (!done && cyc < 60) begin
            // Requests offered while busy must be ignored.
            req_valid = 1'(($urandom_range(0, 1)));
            req_addr  = $urandom; req_func3 = 3'($urandom); req_rd = 5'($urandom);
            mem_rsp_valid = pending |
                ((o_mem_req_valid | o_rsp_valid) & ($urandom_range(0, 3) == 0));
            mem_rsp_data  = pending ? pend_data : {$urandom, $urandom};
            pending = 0;
            if (o_mem_req_valid) begin
                if (!seen) begin
                    seen = 1; hold_addr = o_mem_req_addr;
                end else begin
                    check_val("mem_addr_stable", {32'h0, o_mem_req_addr}, {32'h0, hold_addr});
                end
                if (stall_left > 0) begin
                    mem_req_ready = 1'b0; stall_left--;
                end else begin
                    mem_req_ready = 1'b1;
                    if (nbeats < 2) beat_addr[nbeats] = o_mem_req_addr;
                    nbeats++;
                    pending = 1; pend_data = read_bytes(o_mem_req_addr, nb);
                    seen = 0; stall_left = req_stall;
                end
            end else begin
                mem_req_ready = 1'(($urandom_range(0, 1)));
            end
            if (o_rsp_valid) begin
                if (!got_rsp) begin
                    got_rsp = 1;
                    check_val("rsp_latency", 64'(cyc), 64'(exp_lat));
                    check_val("rsp_data", o_rsp_data, exp_data);
                    check_val("rsp_err", {63'h0, o_rsp_err}, {63'h0, illegal});
                    check_val("rsp_misaligned", {63'h0, o_rsp_mis}, {63'h0, mis});
                    check_val("rsp_rd", {59'h0, o_rsp_rd}, {59'h0, rd});
                    snap_data = o_rsp_data; snap_flags = {o_rsp_rd, o_rsp_mis, o_rsp_err};
                end else begin
                    check_val("rsp_data_stable", o_rsp_data, snap_data);
                    check_val("rsp_flags_stable", {57'h0, o_rsp_rd, o_rsp_mis, o_rsp_err},
                              {57'h0, snap_flags});
                end
                if (rsp_left > 0) begin
                    rsp_ready = 1'b0; rsp_left--;
                end else begin
                    rsp_ready = 1'b1; done = 1;
                end
            end else begin
                rsp_ready = 1'(($urandom_range(0, 1)));
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 1'b0; rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        check_val("load_completed", {63'h0, done}, 64'h1);
        check_val("beat_count", 64'(nbeats), 64'(exp_beats));
        if (exp_beats >= 1 && nbeats >= 1)
            check_val("beat0_addr", {32'h0, beat_addr[0]}, {32'h0, base});
        if (exp_beats == 2 && nbeats >= 2)
            check_val("beat1_addr", {32'h0, beat_addr[1]}, {32'h0, base + 32'(nb)});
        check_val("req_ready_after", {63'h0, o_req_ready}, 64'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_ready"}, {63'h0, o_req_ready}, 64'h0);
        check_val({tag, "_mem_req_valid"}, {63'h0, o_mem_req_valid}, 64'h0);
        check_val({tag, "_mem_req_addr"}, {32'h0, o_mem_req_addr}, 64'h0);
        check_val({tag, "_rsp_valid"}, {63'h0, o_rsp_valid}, 64'h0);
        check_val({tag, "_rsp_data"}, o_rsp_data, 64'h0);
        check_val({tag, "_rsp_rd"}, {59'h0, o_rsp_rd}, 64'h0);
        check_val({tag, "_rsp_flags"}, {62'h0, o_rsp_mis, o_rsp_err}, 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        sel64 = 1'b0; check_reset_outputs("rst32");
        sel64 = 1'b1; check_reset_outputs("rst64");
        sel64 = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("req_ready_after_release", {63'h0, o_req_ready}, 64'h1);

        put_word(32'h1000, 32'h80FF1234);
        run_load(32'h1003, 3'b000, 5'd3, 0, 0);
        put_word(32'h1000, 32'hAABBCCDD);
        put_word(32'h1004, 32'h11223344);
        run_load(32'h1002, 3'b010, 5'd9, 0, 0);
        run_load(32'h1003, 3'b101, 5'd10, 0, 0);
        put_word(32'h1004, 32'h112233C4);
        run_load(32'h1003, 3'b001, 5'd11, 0, 0);
        run_load(32'hFFFF_FFFE, 3'b010, 5'd12, 3, 2);
        run_load(32'h1000, 3'b011, 5'd13, 0, 1);
        run_load(32'h1001, 3'b110, 5'd14, 0, 0);
        run_load(32'h1001, 3'b111, 5'd15, 0, 0);

        for (int i = 0; i < 64; i++) mem[32'h3000 + 32'(i)] = 8'($urandom);
        for (int i = 0; i < 40; i++)
            run_load(32'h3000 + 32'($urandom_range(0, 55)), 3'($urandom), 5'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 2));

        sel64 = 1'b1;
        for (int i = 0; i < 16; i++) mem[32'h2000 + 32'(i)] = 8'($urandom);
        run_load(32'h2005, 3'b011, 5'd21, 0, 0);
        run_load(32'h2006, 3'b110, 5'd22, 1, 0);
        run_load(32'hFFFF_FFFB, 3'b010, 5'd23, 0, 0);
        for (int i = 0; i < 30; i++)
            run_load(32'h3000 + 32'($urandom_range(0, 55)), 3'($urandom), 5'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 2));

        // Reset during the second beat of a misaligned load.
        sel64 = 1'b0;
        put_word(32'h1000, 32'hAABBCCDD);
        put_word(32'h1004, 32'h11223344);
        mem_req_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h1002; req_func3 = 3'b010; req_rd = 5'd7;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_data = read_bytes(32'h1000, 4);
        @(posedge clk); #1; mem_rsp_valid = 1'b0;
        check_val("rst_mid_req1_valid", {63'h0, o_mem_req_valid}, 64'h1);
        check_val("rst_mid_req1_addr", {32'h0, o_mem_req_addr}, 64'h1004);
        @(posedge clk); #1;
        #2 rst_n = 1'b0; #1;
        check_reset_outputs("rst_mid");
        mem_req_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_mid_req_ready", {63'h0, o_req_ready}, 64'h1);
        mem_rsp_valid = 1'b1; mem_rsp_data = read_bytes(32'h1004, 4);
        @(posedge clk); #1; mem_rsp_valid = 1'b0;
        check_val("late_rsp_ignored_valid", {63'h0, o_rsp_valid}, 64'h0);
        check_val("late_rsp_ignored_mem", {63'h0, o_mem_req_valid}, 64'h0);
        put_word(32'h2000, 32'h0000AB00);
        run_load(32'h2001, 3'b100, 5'd5, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
